// File: rtl/main_mem_model.sv
// main_mem_model: fixed-latency single-outstanding word memory behind cache_mem
// Ports: clk, reset (sync, active-high); req_valid/req_ready/req_write/req_addr/req_wdata request channel;
//        resp_valid/resp_ready/resp_rdata/resp_err response channel (rdata echoes wdata for writes).
// Optional: define MAIN_MEM_BOUNDS_CHECK_EN to flag req_addr >= DEPTH*4 (write suppressed, read 0, resp_err=1).
module main_mem_model #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH         = 1024,
  parameter int LATENCY       = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  wr_q, wr_d, err_q, err_d, resp_err_q, resp_err_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  mem_we, addr_oob, unused_addr;
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
  assign addr_oob = (req_addr >> (IW + 2)) != '0;
`else
  assign addr_oob = 1'b0;
`endif
  // byte-offset bits never matter; high bits only matter with the bounds check
  assign unused_addr = ^{req_addr[1:0], req_addr >> (IW + 2)};
  assign req_ready   = state_q == IDLE;
  assign resp_valid  = state_q == RESP;
  assign resp_rdata  = rdata_q;
  assign resp_err    = resp_err_q;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    resp_err_d = resp_err_q;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = BUSY;
        cnt_d   = CW'(LATENCY - 1);
        wr_d    = req_write;
        idx_d   = req_addr[2 +: IW];
        wdata_d = req_wdata;
        err_d   = addr_oob;
      end
      BUSY: if (cnt_q == '0) begin
        state_d    = RESP;
        // reset on the commit edge wins, so the write is dropped
        mem_we     = wr_q && !err_q && !reset;
        rdata_d    = wr_q ? wdata_q : err_q ? '0 : mem[idx_q];
        resp_err_d = err_q;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      resp_err_q <= resp_err_d;
    end
  end
  // storage is deliberately not reset so contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= wdata_q;
  end
endmodule

// File: tb/tb_main_mem_model.sv
// tb_main_mem_model: randomized self-checking bench for main_mem_model against a word-array reference
module tb_main_mem_model;
  localparam int DEPTH   = 1024;
  localparam int LATENCY = 4;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] ref_mem [DEPTH];
  bit          ref_known [DEPTH];
  int          n_cmp = 0;
  int          n_err = 0;
  main_mem_model #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] d, input int hold);
    int          idx, cyc;
    bit          oob, known;
    logic [31:0] exp, held;
    idx = int'((a / 4) % DEPTH);
    oob = 1'b0;
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
    oob = a >= DEPTH * 4;
`endif
    known = w ? !oob : (oob || ref_known[idx]);
    exp   = w ? d : (oob ? 32'h0 : ref_mem[idx]);
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    #1;
    req_valid = 1'($urandom_range(0, 1));
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    if (w && !oob) begin
      ref_mem[idx]   = d;
      ref_known[idx] = 1'b1;
    end
    cyc = 0;
    do begin
      check("req_ready_busy", req_ready, 0);
      @(posedge clk);
      #1;
      cyc++;
    end while (!resp_valid && cyc < LATENCY + 8);
    check("latency", cyc, LATENCY);
    held = resp_rdata;
    if (known) check("resp_rdata", resp_rdata, exp);
    check("resp_err", resp_err, oob);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h0000_0100;
      req_wdata = $urandom;
      @(posedge clk);
      #1;
      check("hold_valid", resp_valid, 1);
      check("hold_rdata", resp_rdata, held);
      check("hold_ready", req_ready, 0);
    end
    req_valid  = 1'b1;
    req_write  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    check("resp_drop", resp_valid, 0);
    check("no_turnaround", req_ready, 1);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] a;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err", resp_err, 0);
    xact(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    xact(1'b0, 32'h0000_0010, 32'h0, 0);
    xact(1'b1, 32'h0000_0100, 32'h1111_1111, 0);
    xact(1'b0, 32'h0000_0010, 32'h0, 3);
    xact(1'b0, 32'h0000_0100, 32'h0, 0);
    xact(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 0);
    xact(1'b1, 32'h0001_0100, 32'hCAFE_BABE, 0);
    xact(1'b0, 32'h0000_0100, 32'h0, 0);
    xact(1'b0, 32'h0001_0100, 32'h0, 0);
    xact(1'b1, 32'h0000_0020, 32'hAAAA_AAAA, 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0000_0020;
    req_wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_req_ready", req_ready, 1);
    check("abort_resp_valid", resp_valid, 0);
    for (int i = 0; i < LATENCY + 2; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_resp", resp_valid, 0);
    end
    xact(1'b0, 32'h0000_0020, 32'h0, 0);
    xact(1'b1, 32'h0000_0000, 32'h5555_5555, 0);
    xact(1'b1, 32'h0000_1000, 32'h7777_7777, 0);
    xact(1'b0, 32'h0000_1000, 32'h0, 0);
    xact(1'b0, 32'h0000_0000, 32'h0, 0);
    for (int n = 0; n < 40; n++) begin
      a = (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 3)) << 12) | 32'($urandom_range(0, 3));
      xact(1'($urandom), a, $urandom, int'($urandom_range(0, 3)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
